// File: rtl/serial_mem_master.sv
// Serial-command memory initiator: 'W' addr[4] data[4] writes a word, 'R' addr[4] reads one and replies with 4 bytes.
// Optional macro SERIAL_MEM_MASTER_WRACK_EN adds an ACK state that answers each accepted write with '.'.
module serial_mem_master #(
  parameter logic [1:0] MEM_ID = 2'd3
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        rs232in_attention,
  input  logic [7:0]  rs232in_data,
  input  logic        rs232out_busy,
  output logic        rs232out_w,
  output logic [7:0]  rs232out_d,
  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_REQ    = 3'd3,
    S_WAITRD = 3'd4,
`ifdef SERIAL_MEM_MASTER_WRACK_EN
    S_SEND   = 3'd5,
    S_ACK    = 3'd6
`else
    S_SEND   = 3'd5
`endif
  } state_t;

  state_t      state_r;
  logic [1:0]  cnt_r;
  logic        is_wr_r;
  logic [31:0] addr_r;
  logic [23:0] data_r;
  logic [31:0] tx_r;

  logic [31:0] addr_nxt_s;
  logic [31:0] data_nxt_s;
  logic        tx_ok_s;

  assign addr_nxt_s = {addr_r[23:0], rs232in_data};
  assign data_nxt_s = {data_r, rs232in_data};
  // A new strobe needs an idle transmitter and a gap cycle after the previous strobe.
  assign tx_ok_s    = !rs232out_busy && !rs232out_w;

  // Command FSM with registered memory and serial outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r           <= S_IDLE;
      cnt_r             <= 2'd0;
      is_wr_r           <= 1'b0;
      addr_r            <= 32'd0;
      data_r            <= 24'd0;
      tx_r              <= 32'd0;
      rs232out_w        <= 1'b0;
      rs232out_d        <= 8'd0;
      mem_id            <= MEM_ID;
      mem_address       <= 30'd0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      mem_writedata     <= 32'd0;
      mem_writedatamask <= 4'h0;
    end else begin
      rs232out_w <= 1'b0;
      mem_id     <= MEM_ID;
      case (state_r)
        S_IDLE: begin
          if (rs232in_attention && (rs232in_data == 8'h57 || rs232in_data == 8'h52)) begin
            is_wr_r <= (rs232in_data == 8'h57);
            cnt_r   <= 2'd0;
            state_r <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rs232in_attention) begin
            addr_r <= addr_nxt_s;
            cnt_r  <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              if (is_wr_r) begin
                state_r <= S_DATA;
              end else begin
                mem_read          <= 1'b1;
                mem_write         <= 1'b0;
                mem_address       <= addr_nxt_s[31:2];
                mem_writedatamask <= 4'h0;
                state_r           <= S_REQ;
              end
            end
          end
        end
        S_DATA: begin
          if (rs232in_attention) begin
            data_r <= data_nxt_s[23:0];
            cnt_r  <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              mem_write         <= 1'b1;
              mem_read          <= 1'b0;
              mem_address       <= addr_r[31:2];
              mem_writedata     <= data_nxt_s;
              mem_writedatamask <= 4'hF;
              state_r           <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Outputs are held untouched until the slave drops waitrequest.
          if (!mem_waitrequest) begin
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_writedatamask <= 4'h0;
            if (mem_read) begin
              state_r <= S_WAITRD;
            end else begin
`ifdef SERIAL_MEM_MASTER_WRACK_EN
              state_r <= S_ACK;
`else
              state_r <= S_IDLE;
`endif
            end
          end
        end
        S_WAITRD: begin
          if (mem_readdataid == MEM_ID) begin
            state_r <= S_SEND;
            if (tx_ok_s) begin
              rs232out_w <= 1'b1;
              rs232out_d <= mem_readdata[31:24];
              tx_r       <= {mem_readdata[23:0], 8'h00};
              cnt_r      <= 2'd1;
            end else begin
              tx_r  <= mem_readdata;
              cnt_r <= 2'd0;
            end
          end
        end
        S_SEND: begin
          if (tx_ok_s) begin
            rs232out_w <= 1'b1;
            rs232out_d <= tx_r[31:24];
            tx_r       <= {tx_r[23:0], 8'h00};
            cnt_r      <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              state_r <= S_IDLE;
            end
          end
        end
`ifdef SERIAL_MEM_MASTER_WRACK_EN
        S_ACK: begin
          if (tx_ok_s) begin
            rs232out_w <= 1'b1;
            rs232out_d <= 8'h2E;
            state_r    <= S_IDLE;
          end
        end
`endif
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mem_master.sv
// Scoreboard bench for serial_mem_master: expected memory requests and reply bytes are queued when commands are sent.
module tb_serial_mem_master;

  localparam logic [1:0] MEM_ID = 2'd3;

  logic        clock = 1'b0;
  logic        rst;
  logic        rs232in_attention;
  logic [7:0]  rs232in_data;
  logic        rs232out_busy;
  logic        rs232out_w;
  logic [7:0]  rs232out_d;
  logic        mem_waitrequest;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_readdataid;

  serial_mem_master #(.MEM_ID(MEM_ID)) dut (
    .clock             (clock),
    .rst               (rst),
    .rs232in_attention (rs232in_attention),
    .rs232in_data      (rs232in_data),
    .rs232out_busy     (rs232out_busy),
    .rs232out_w        (rs232out_w),
    .rs232out_d        (rs232out_d),
    .mem_waitrequest   (mem_waitrequest),
    .mem_id            (mem_id),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_writedatamask (mem_writedatamask),
    .mem_readdata      (mem_readdata),
    .mem_readdataid    (mem_readdataid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [31:0] data;
    int          hi;
  } exp_mem_t;

  exp_mem_t   exp_mem[$];
  logic [7:0] exp_tx[$];
  logic [7:0] byte_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Transmitter model: busy for 3 cycles after every strobe.
  int busy_cnt = 0;
  assign rs232out_busy = (busy_cnt != 0);
  always @(posedge clock) begin
    if (rs232out_w) busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Slave model: waitrequest held for wait_cfg cycles of each request.
  int wait_cfg = 0;
  int stall_cnt = 0;
  assign mem_waitrequest = (mem_read || mem_write) && (stall_cnt < wait_cfg);
  always @(posedge clock) begin
    if (mem_read || mem_write) begin
      if (mem_waitrequest) stall_cnt <= stall_cnt + 1;
    end else begin
      stall_cnt <= 0;
    end
  end

  // Monitor: request acceptance, request stability, strobe shape and reply bytes.
  int          hi_cnt = 0;
  int          acc_cnt = 0;
  int          tx_cnt = 0;
  logic        prev_strobe = 1'b0, prev_wait = 1'b0, prev_rst = 1'b1, prev_acc = 1'b0, prev_w = 1'b0;
  logic [29:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [7:0]  prev_ctrl;
  exp_mem_t    mon_e;
  always @(negedge clock) begin
    logic strobe;
    logic acc;
    strobe = mem_read || mem_write;
    acc    = strobe && !mem_waitrequest && !rst;
    if (prev_strobe && prev_wait && !prev_rst) begin
      check_eq("req_stable_addr", {2'b00, mem_address}, {2'b00, prev_addr});
      check_eq("req_stable_wdata", mem_writedata, prev_wdata);
      check_eq("req_stable_ctrl", {24'd0, mem_read, mem_write, mem_writedatamask, mem_id}, {24'd0, prev_ctrl});
    end
    if (prev_acc) check_eq("strobe_drop", {31'd0, strobe}, 32'd0);
    if (strobe) hi_cnt++;
    else hi_cnt = 0;
    if (acc) begin
      acc_cnt++;
      check_eq("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
      check_eq("mem_expected", {31'd0, exp_mem.size() != 0}, 32'd1);
      if (exp_mem.size() != 0) begin
        mon_e = exp_mem.pop_front();
        check_eq("req_kind", {31'd0, mem_write}, {31'd0, mon_e.wr});
        check_eq("req_addr", {2'b00, mem_address}, {2'b00, mon_e.addr});
        check_eq("req_mask", {28'd0, mem_writedatamask}, mon_e.wr ? 32'hF : 32'h0);
        check_eq("req_id", {30'd0, mem_id}, {30'd0, MEM_ID});
        check_eq("req_cycles", hi_cnt, mon_e.hi);
        if (mon_e.wr) check_eq("req_wdata", mem_writedata, mon_e.data);
      end
    end
    if (prev_w) check_eq("tx_pulse", {31'd0, rs232out_w}, 32'd0);
    if (rs232out_w) begin
      tx_cnt++;
      check_eq("tx_busy", {31'd0, rs232out_busy}, 32'd0);
      check_eq("tx_expected", {31'd0, exp_tx.size() != 0}, 32'd1);
      if (exp_tx.size() != 0) check_eq("tx_byte", {24'd0, rs232out_d}, {24'd0, exp_tx.pop_front()});
    end
    prev_strobe = strobe;
    prev_wait   = mem_waitrequest;
    prev_rst    = rst;
    prev_acc    = acc;
    prev_w      = rs232out_w;
    prev_addr   = mem_address;
    prev_wdata  = mem_writedata;
    prev_ctrl   = {mem_read, mem_write, mem_writedatamask, mem_id};
  end

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(posedge clock);
    @(posedge clock); #1;
    rs232in_attention = 1'b1;
    rs232in_data      = b;
    @(posedge clock); #1;
    rs232in_attention = 1'b0;
  endtask

  task automatic send_q();
    foreach (byte_q[i]) send_byte(byte_q[i]);
  endtask

  task automatic push_mem(input logic wr, input logic [29:0] addr, input logic [31:0] data, input int hi);
    exp_mem_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.hi = hi;
    exp_mem.push_back(e);
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_tx.push_back(w[31:24]);
    exp_tx.push_back(w[23:16]);
    exp_tx.push_back(w[15:8]);
    exp_tx.push_back(w[7:0]);
  endtask

  task automatic ret(input logic [1:0] id, input logic [31:0] data);
    @(posedge clock); #1;
    mem_readdataid = id;
    mem_readdata   = data;
    @(posedge clock); #1;
    mem_readdataid = 2'd0;
    mem_readdata   = 32'd0;
  endtask

  task automatic wait_acc(input int start);
    for (int i = 0; i < 200; i++) begin
      if (acc_cnt != start) break;
      @(posedge clock); #1;
    end
    check_eq("acc_wait", acc_cnt - start, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (exp_tx.size() == 0 && exp_mem.size() == 0 && busy_cnt == 0) break;
      @(posedge clock); #1;
    end
    repeat (6) @(posedge clock);
    #1;
    check_eq("drain", exp_tx.size() + exp_mem.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0;
    int t0;
    rst = 1'b1;
    rs232in_attention = 1'b0;
    rs232in_data = 8'd0;
    mem_readdata = 32'd0;
    mem_readdataid = 2'd0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_read", {31'd0, mem_read}, 32'd0);
    check_eq("rst_write", {31'd0, mem_write}, 32'd0);
    check_eq("rst_w", {31'd0, rs232out_w}, 32'd0);
    check_eq("rst_mask", {28'd0, mem_writedatamask}, 32'd0);
    check_eq("rst_addr", {2'b00, mem_address}, 32'd0);
    check_eq("rst_wdata", mem_writedata, 32'd0);
    check_eq("rst_d", {24'd0, rs232out_d}, 32'd0);
    check_eq("rst_id", {30'd0, mem_id}, {30'd0, MEM_ID});
    rst = 1'b0;

    // Word write, no wait states.
    push_mem(1'b1, 30'h1000_0040, 32'hDEAD_BEEF, 1);
`ifdef SERIAL_MEM_MASTER_WRACK_EN
    exp_tx.push_back(8'h2E);
`endif
    byte_q = '{8'h57, 8'h40, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_q();
    drain();

    // Word read with 3 wait states, checking request and reply latency.
    wait_cfg = 3;
    push_mem(1'b0, 30'h1000_0040, 32'd0, 4);
    push_word(32'h1234_5678);
    a0 = acc_cnt;
    byte_q = '{8'h52, 8'h40, 8'h00, 8'h01, 8'h00};
    send_q();
    check_eq("rd_latency", {31'd0, mem_read}, 32'd1);
    wait_acc(a0);
    ret(MEM_ID, 32'h1234_5678);
    check_eq("tx_latency", {31'd0, rs232out_w}, 32'd1);
    drain();

    // Foreign id return is ignored.
    wait_cfg = 0;
    push_mem(1'b0, 30'h0000_0008, 32'd0, 1);
    push_word(32'h0000_ABCD);
    a0 = acc_cnt;
    byte_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
    send_q();
    wait_acc(a0);
    ret(2'd1, 32'hFFFF_FFFF);
    ret(MEM_ID, 32'h0000_ABCD);
    drain();

    // Junk bytes before a write, with 2 wait states.
    wait_cfg = 2;
    push_mem(1'b1, 30'h0000_0002, 32'hCAFE_F00D, 3);
`ifdef SERIAL_MEM_MASTER_WRACK_EN
    exp_tx.push_back(8'h2E);
`endif
    byte_q = '{8'h41, 8'h00, 8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_q();
    drain();

    // Reset while a read is stalled; the late return must be ignored.
    wait_cfg = 1000;
    a0 = acc_cnt;
    byte_q = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00};
    send_q();
    check_eq("rst_pre_read", {31'd0, mem_read}, 32'd1);
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    check_eq("rst_mid_read", {31'd0, mem_read}, 32'd0);
    check_eq("rst_mid_addr", {2'b00, mem_address}, 32'd0);
    wait_cfg = 0;
    t0 = tx_cnt;
    ret(MEM_ID, 32'h5555_AAAA);
    repeat (20) @(posedge clock);
    #1;
    check_eq("no_tx_after_rst", tx_cnt - t0, 32'd0);
    check_eq("no_acc_after_rst", acc_cnt - a0, 32'd0);

    // Byte arriving during SEND is dropped; a fresh read follows.
    push_mem(1'b0, 30'h0000_0010, 32'd0, 1);
    push_word(32'hA5A5_0F0F);
    a0 = acc_cnt;
    byte_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h40};
    send_q();
    wait_acc(a0);
    ret(MEM_ID, 32'hA5A5_0F0F);
    send_byte(8'h57);
    drain();
    push_mem(1'b0, 30'h0000_0004, 32'd0, 1);
    push_word(32'h89AB_CDEF);
    a0 = acc_cnt;
    byte_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
    send_q();
    wait_acc(a0);
    ret(MEM_ID, 32'h89AB_CDEF);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
